muldiv_unit_p: RTL and testbench
================================

Name: muldiv_unit_p

Overview:
Parametrised multicycle multiply/divide unit that owns the HI/LO register pair for the multicycle CPU datapath. The control unit launches MULT/MULTU/DIV/DIVU with a one-cycle start pulse and polls done / div_zero. The hi/lo outputs feed the MemToReg mux inputs for MFHI/MFLO, which the datapath currently ties to zero. div_zero drives the control unit's transition to the divide-by-zero exception (vector 255).

Parameters:
WIDTH, 32, operand and HI/LO width in bits; legal range is 2 or greater.

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  launch request; sampled only in IDLE
op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  in  WIDTH  multiplicand / dividend (register A)
b  in  WIDTH  multiplier / divisor (register B)
wr_hi  in  1  MTHI: load wr_data into HI
wr_lo  in  1  MTLO: load wr_data into LO
wr_data  in  WIDTH  data for wr_hi / wr_lo
hi  out  WIDTH  HI register (product high half / remainder)
lo  out  WIDTH  LO register (product low half / quotient)
busy  out  1  operation in progress
done  out  1  one-cycle pulse; hi/lo hold the new result
div_zero  out  1  one-cycle pulse; DIV/DIVU with b==0 was rejected

Behaviour:
- Reset: synchronous, active-high. All outputs are 0 after the edge: hi, lo, busy, done, div_zero. FSM goes to IDLE and the iteration counter goes to 0. Reset mid-operation aborts the operation; no partial result reaches hi/lo.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; exactly WIDTH iterations, counter 0..WIDTH-1.
  - FIN: writes hi/lo.
  - DZ: rejects the divide.
- Launch: start=1 in IDLE at edge E0.
  - a, b and op are latched at E0.
  - For signed ops, operand magnitudes and result signs are captured at E0.
  - a and b may change after E0.
- Multiply: radix-2 shift-add on magnitudes, one bit per cycle in RUN, 2*WIDTH-bit accumulator. For MULT the final 2*WIDTH result is negated if the operand signs differ. Result: {hi,lo} = full 2*WIDTH-bit product.
- Divide: restoring divide on magnitudes, one quotient bit per cycle.
  - lo = quotient, truncated toward zero.
  - hi = remainder, taking the sign of the dividend (signed DIV).
  - DIV of most-negative / -1 gives lo = most-negative value (2^(WIDTH-1)) and hi = 0. No flag is raised.
- Timing: busy=1 from E0 through the cycle before E0+WIDTH+1. At edge E0+WIDTH+1:
  - hi/lo are written;
  - done goes to 1 for exactly one cycle;
  - busy goes to 0 and the FSM returns to IDLE.
  Total latency is WIDTH+1 cycles.
- Divide by zero: DIV/DIVU accepted with b==0 at E0 goes to DZ. At E0+1 div_zero=1 for one cycle, done stays 0, hi/lo are unchanged, and the FSM returns to IDLE. busy=1 only during the DZ cycle.
- start while busy (RUN/FIN/DZ) is ignored: no queueing, no effect on the running operation.
- wr_hi/wr_lo:
  - Honoured in IDLE only; ignored in every other state.
  - Both asserted together load both registers.
  - Asserted in the same cycle as an accepted start: the write takes effect at E0, and the result later overwrites it.
- start=1 while done=1 (first IDLE cycle after FIN) is accepted normally, so back-to-back operations are allowed.
- hi/lo hold their value except on FIN, an IDLE write, or reset.

Test Plan:
- Signed multiply, WIDTH=32, MULT a=0xFFFFFFFD (-3), b=7, start pulse at E0 -> busy high for 33 cycles; done pulse at E0+33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Unsigned multiply, MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Repeat as MULT -> hi=0, lo=1.
- Signed divide:
  - DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7, b=2 -> lo=3, hi=1.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x1234, lo=0x5678 via wr_hi/wr_lo, then DIVU a=7, b=0 -> div_zero=1 at E0+1 for one cycle; done never pulses; hi/lo remain 0x1234 / 0x5678.
- Ignored inputs: start with a new op and wr_lo=1 at cycle E0+5 of a MULT 6*7 -> both ignored; result hi=0, lo=42 at E0+33; next start accepted in the done cycle.
- Reset mid-operation: reset at E0+10 of a DIVU -> hi, lo, busy, done and div_zero are 0 after the edge. A following MULTU 3*5 completes with lo=15 after 33 cycles. Repeat a MULT case with WIDTH=8 and check done at E0+9.

Source files
------------

// File: rtl/muldiv_unit_p.sv
// Multicycle multiply/divide unit owning the HI/LO register pair.
// Radix-2 shift-add multiply and restoring divide run on operand magnitudes,
// one bit per cycle; signs are reapplied when the result is written.
module muldiv_unit_p #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int W  = WIDTH;
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CONE  = CW'(1);
  localparam logic [W-1:0]  ONE   = W'(1);
  localparam logic [W2-1:0] ONE2  = W2'(1);
  localparam logic [W-1:0]  ZERO  = '0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_DZ} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, dz_q;
  logic [W-1:0]    hi_q, lo_q;

  logic            is_div_q, qneg_q, rneg_q;
  logic [W-1:0]    opnd_q;
  logic [W2-1:0]   acc_q;

  logic            accept;
  logic            a_neg, b_neg;
  logic [W-1:0]    mag_a, mag_b;
  logic [W-1:0]    res_hi, res_lo;

  function automatic logic [W-1:0] negw(input logic [W-1:0] x);
    return ~x + ONE;
  endfunction

  function automatic logic [W2-1:0] neg2w(input logic [W2-1:0] x);
    return ~x + ONE2;
  endfunction

  // One shift-add step: conditionally add multiplicand to the upper half, shift right.
  function automatic logic [W2-1:0] mul_step(input logic [W2-1:0] acc, input logic [W-1:0] m);
    logic [W:0] sum;
    sum = {1'b0, acc[W2-1:W]} + (acc[0] ? {1'b0, m} : {1'b0, ZERO});
    return {sum, acc[W-1:1]};
  endfunction

  // One restoring step: shift next dividend bit into the remainder, subtract if it fits.
  function automatic logic [W2-1:0] div_step(input logic [W2-1:0] acc, input logic [W-1:0] d);
    logic [W:0] cand;
    logic       qbit;
    cand = {acc[W2-1:W], acc[W-1]};
    qbit = (cand >= {1'b0, d});
    if (qbit) cand = cand - {1'b0, d};
    return {cand[W-1:0], acc[W-2:0], qbit};
  endfunction

  assign accept = (state_q == S_IDLE) && start;
  assign a_neg  = ~op[0] & a[W-1];
  assign b_neg  = ~op[0] & b[W-1];
  assign mag_a  = a_neg ? negw(a) : a;
  assign mag_b  = b_neg ? negw(b) : b;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and iteration counter
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: if (start) state_d = (op[1] && (b == ZERO)) ? S_DZ : S_RUN;
      S_RUN: begin
        if (cnt_q == LAST) state_d = S_FIN;
        else               cnt_d   = cnt_q + CONE;
      end
      S_FIN:   state_d = S_IDLE;
      S_DZ:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Operand capture at launch, then one iteration per RUN cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div_q <= op[1];
      qneg_q   <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
      opnd_q   <= op[1] ? mag_b : mag_a;
      acc_q    <= op[1] ? {ZERO, mag_a} : {ZERO, mag_b};
    end else if (state_q == S_RUN) begin
      acc_q <= is_div_q ? div_step(acc_q, opnd_q) : mul_step(acc_q, opnd_q);
    end
  end

  // Sign correction of the finished magnitude result
  always_comb begin
    logic [W2-1:0] prod;
    prod   = qneg_q ? neg2w(acc_q) : acc_q;
    res_hi = prod[W2-1:W];
    res_lo = prod[W-1:0];
    if (is_div_q) begin
      res_lo = qneg_q ? negw(acc_q[W-1:0])  : acc_q[W-1:0];
      res_hi = rneg_q ? negw(acc_q[W2-1:W]) : acc_q[W2-1:W];
    end
  end

  // Counter, status pulses and HI/LO updates
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (state_q == S_FIN);
      dz_q   <= (state_q == S_DZ);
      if (state_q == S_FIN) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (state_q == S_IDLE) begin
        if (wr_hi) hi_q <= wr_data;
        if (wr_lo) lo_q <= wr_data;
      end
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit_p.sv
// Scoreboard bench for muldiv_unit_p: a 32-bit and an 8-bit instance.
module tb_muldiv_unit_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] a, b, wr_data, hi, lo;
  logic        busy, done, div_zero;

  logic        start8, wr_hi8, wr_lo8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wr_data8, hi8, lo8;
  logic        busy8, done8, dz8;

  int checks = 0, failures = 0, cyc = 0, e0 = 0;

  logic        qdz[$];
  logic [31:0] qhi[$], qlo[$];
  string       qname[$];
  logic [7:0]  q8hi[$], q8lo[$];
  string       q8name[$];

  muldiv_unit_p #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero));

  muldiv_unit_p #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .wr_hi(wr_hi8), .wr_lo(wr_lo8), .wr_data(wr_data8),
    .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div_zero(dz8));

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for the 32-bit unit
  always @(negedge clk) begin
    if (done || div_zero) begin
      checks++;
      if (qdz.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse done=%b div_zero=%b hi=%h lo=%h", done, div_zero, hi, lo);
      end else begin
        logic edz; logic [31:0] eh, el; string nm;
        edz = qdz.pop_front(); eh = qhi.pop_front(); el = qlo.pop_front(); nm = qname.pop_front();
        if (div_zero !== edz || done !== !edz || hi !== eh || lo !== el) begin
          failures++;
          $display("FAIL %s got done=%b dz=%b hi=%h lo=%h, expected dz=%b hi=%h lo=%h",
                   nm, done, div_zero, hi, lo, edz, eh, el);
        end
      end
    end
  end

  // Monitor for the 8-bit unit
  always @(negedge clk) begin
    if (done8 || dz8) begin
      checks++;
      if (q8hi.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse8 done=%b dz=%b", done8, dz8);
      end else begin
        logic [7:0] eh, el; string nm;
        eh = q8hi.pop_front(); el = q8lo.pop_front(); nm = q8name.pop_front();
        if (done8 !== 1'b1 || dz8 !== 1'b0 || hi8 !== eh || lo8 !== el) begin
          failures++;
          $display("FAIL %s got done=%b dz=%b hi=%h lo=%h, expected hi=%h lo=%h",
                   nm, done8, dz8, hi8, lo8, eh, el);
        end
      end
    end
  end

  task automatic expect_res(input string nm, input logic dz, input logic [31:0] h, input logic [31:0] l);
    qname.push_back(nm); qdz.push_back(dz); qhi.push_back(h); qlo.push_back(l);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb, input bit now);
    if (!now) @(negedge clk);
    start = 1'b1; op = o; a = aa; b = bb;
    e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0; a = ~aa; b = ~bb; op = ~o;
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // Waits for done/div_zero, then checks latency from E0 and the number of busy cycles
  task automatic wait_result(input string nm, input int exp_lat, input bit chk_busy);
    int bc = 0, n = 0;
    while (!(done || div_zero) && n < 200) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL %s_timeout got no pulse within 200 cycles, expected one", nm);
    end else begin
      check({nm, "_latency"}, 64'(cyc - e0), 64'(exp_lat));
      if (chk_busy) check({nm, "_busy_cycles"}, 64'(bc), 64'(exp_lat));
    end
  endtask

  task automatic run8(input string nm, input logic [1:0] o, input logic [7:0] aa, input logic [7:0] bb,
                      input logic [7:0] eh, input logic [7:0] el);
    int n = 0;
    q8name.push_back(nm); q8hi.push_back(eh); q8lo.push_back(el);
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = aa; b8 = bb; e0 = cyc + 1;
    @(negedge clk);
    start8 = 1'b0; a8 = ~aa; b8 = ~bb;
    while (!done8 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL %s_timeout got no done within 100 cycles, expected one", nm);
    end else check({nm, "_latency"}, 64'(cyc - e0), 64'd9);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    wr_hi8 = 1'b0; wr_lo8 = 1'b0; wr_data8 = '0;
    repeat (3) @(negedge clk);
    check("reset32", {hi, lo}, 64'd0);
    check("reset32_flags", {61'd0, busy, done, div_zero}, 64'd0);
    check("reset8", {40'd0, hi8, lo8, 5'd0, busy8, done8, dz8}, 64'd0);
    reset = 1'b0;

    // MULT -3 * 7
    expect_res("mult_neg", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);
    issue(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0);
    wait_result("mult_neg", 33, 1'b1);
    @(negedge clk);
    check("done_one_cycle", {62'd0, done, busy}, 64'd0);

    expect_res("multu_max", 1'b0, 32'hFFFFFFFE, 32'h00000001);
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_result("multu_max", 33, 1'b1);

    expect_res("mult_m1m1", 1'b0, 32'h0, 32'h1);
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_result("mult_m1m1", 33, 1'b1);

    expect_res("div_neg", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_result("div_neg", 33, 1'b1);

    expect_res("divu_7_2", 1'b0, 32'd1, 32'd3);
    issue(2'b11, 32'd7, 32'd2, 1'b0);
    wait_result("divu_7_2", 33, 1'b1);

    expect_res("div_ovf", 1'b0, 32'h0, 32'h80000000);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_result("div_ovf", 33, 1'b1);

    // Preload HI/LO, then divide by zero
    @(negedge clk); wr_hi = 1'b1; wr_data = 32'h1234;
    @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h5678;
    @(negedge clk); wr_lo = 1'b0;
    check("preload", {hi, lo}, {32'h1234, 32'h5678});
    expect_res("divu_zero", 1'b1, 32'h1234, 32'h5678);
    issue(2'b11, 32'd7, 32'd0, 1'b1);
    wait_result("divu_zero", 1, 1'b1);
    @(negedge clk);
    check("dz_one_cycle", {62'd0, div_zero, done}, 64'd0);
    check("dz_hilo_kept", {hi, lo}, {32'h1234, 32'h5678});

    // MULT 6*7 with a start and an MTLO injected mid-run
    expect_res("mult_ignore", 1'b0, 32'h0, 32'd42);
    issue(2'b00, 32'd6, 32'd7, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd0; wr_lo = 1'b1; wr_data = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b0;
    wait_result("mult_ignore", 33, 1'b0);
    // Launch in the done cycle: DIV -100 / 7
    expect_res("div_b2b", 1'b0, 32'hFFFFFFFE, 32'hFFFFFFF2);
    issue(2'b10, 32'hFFFFFF9C, 32'd7, 1'b1);
    wait_result("div_b2b", 33, 1'b1);

    // Reset during a DIVU
    issue(2'b11, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midop_reset", {hi, lo}, 64'd0);
    check("midop_reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
    reset = 1'b0;
    expect_res("multu_3_5", 1'b0, 32'h0, 32'd15);
    issue(2'b01, 32'd3, 32'd5, 1'b0);
    wait_result("multu_3_5", 33, 1'b1);

    // 8-bit instance
    run8("mult8_neg", 2'b00, 8'hFD, 8'h07, 8'hFF, 8'hEB);
    run8("div8_ovf", 2'b10, 8'h80, 8'hFF, 8'h00, 8'h80);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(qdz.size() + q8hi.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
